// File: rtl/mc_pkg.sv
// Shared types and encodings for the handshaked multicycle RV32I controller.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_J    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Shared funct3 map for R-type (funct7=0) and I-ALU; MSB flags a supported funct3.
    function automatic logic [3:0] f3_to_aluop(input logic [2:0] f3);
        case (f3)
            3'b000:  return {1'b1, ALU_ADD};
            3'b010:  return {1'b1, ALU_SLT};
            3'b011:  return {1'b1, ALU_SLTU};
            3'b100:  return {1'b1, ALU_XOR};
            3'b110:  return {1'b1, ALU_OR};
            3'b111:  return {1'b1, ALU_AND};
            default: return {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational Op/F3/F7 decode: ALU operation and illegal-instruction flag.
module mc_alu_decode
    import mc_pkg::*;
#(
    parameter bit EN_UPPER = 1'b1,
    parameter bit EN_JALR  = 1'b1
) (
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output logic [2:0] aluop,
    output logic       illegal
);

    logic [3:0] f3_dec;

    assign f3_dec = f3_to_aluop(f3);

    always_comb begin
        aluop   = ALU_ADD;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                if (f7 == F7_ALT && f3 == 3'b000) begin
                    aluop = ALU_SUB;
                end else if (f7 == F7_BASE && f3_dec[3]) begin
                    aluop = f3_dec[2:0];
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                if (f3_dec[3]) begin
                    aluop = f3_dec[2:0];
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LW, OP_SW: illegal = (f3 != 3'b010);
            // beq/bne/blt/bge only: funct3[1] set means bltu/bgeu or reserved
            OP_BR: begin
                aluop   = ALU_SUB;
                illegal = f3[1];
            end
            OP_JAL:            illegal = 1'b0;
            OP_JALR:           illegal = !EN_JALR || (f3 != 3'b000);
            OP_LUI, OP_AUIPC:  illegal = !EN_UPPER;
            default:           illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller_hs.sv
// Multicycle RV32I control FSM with memory request/ready handshake, wait-state
// timeout, sticky error reporting and a retired-instruction counter.
module mc_controller_hs
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter bit          EN_UPPER    = 1'b1,
    parameter bit          EN_JALR     = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic [2:0]       F3,
    input  logic [6:0]       F7,
    input  logic             Zero,
    input  logic             SignBit,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             PcEn,
    output logic             IrWrite,
    output logic             RegWrite,
    output logic [2:0]       Immsrc,
    output logic [1:0]       AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [2:0]       AluOp,
    output logic [1:0]       ResultSrc,
    output logic             Err,
    output logic [1:0]       ErrCode,
    output logic [CNT_W-1:0] InstRet
);

    localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t             state;
    state_t             state_next;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic               retire;
    logic [1:0]         err_code_next;
    logic               err_q;
    logic [1:0]         err_code_q;
    logic [CNT_W-1:0]   inst_ret_q;
    logic [2:0]         dec_aluop;
    logic               dec_illegal;
    logic               br_taken;

    mc_alu_decode #(
        .EN_UPPER (EN_UPPER),
        .EN_JALR  (EN_JALR)
    ) u_alu_decode (
        .op      (Op),
        .f3      (F3),
        .f7      (F7),
        .aluop   (dec_aluop),
        .illegal (dec_illegal)
    );

    // Counter value is the number of prior stalled cycles, so this cycle is stall MEM_TIMEOUT.
    assign tmo_hit = (MEM_TIMEOUT != 0) && !MemReady
                     && (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        case (F3)
            3'b000:  br_taken = Zero;
            3'b001:  br_taken = !Zero;
            3'b100:  br_taken = SignBit;
            3'b101:  br_taken = !SignBit;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next    = state;
        MemReq        = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        PcEn          = 1'b0;
        IrWrite       = 1'b0;
        RegWrite      = 1'b0;
        Immsrc        = IMM_I;
        AluSrcA       = SRCA_PC;
        AluSrcB       = SRCB_RS2;
        AluOp         = ALU_ADD;
        ResultSrc     = RES_ALUOUT;
        retire        = 1'b0;
        err_code_next = ERR_NONE;
        case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                AluSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                if (MemReady) begin
                    IrWrite    = 1'b1;
                    PcEn       = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next    = S_ERROR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                AluSrcA = SRCA_OLDPC;
                AluSrcB = SRCB_IMM;
                if (Op == OP_BR) begin
                    Immsrc = IMM_B;
                end else if (Op == OP_JAL) begin
                    Immsrc = IMM_J;
                end
                if (dec_illegal) begin
                    state_next    = S_ERROR;
                    err_code_next = ERR_ILLEGAL;
                end else begin
                    case (Op)
                        OP_R:           state_next = S_EXEC_R;
                        OP_I, OP_JALR:  state_next = S_EXEC_I;
                        OP_LW, OP_SW:   state_next = S_MEM_ADDR;
                        OP_BR:          state_next = S_BRANCH;
                        OP_JAL:         state_next = S_JAL;
                        OP_LUI:         state_next = S_LUI;
                        OP_AUIPC:       state_next = S_AUIPC;
                        default: begin
                            state_next    = S_ERROR;
                            err_code_next = ERR_ILLEGAL;
                        end
                    endcase
                end
            end
            S_EXEC_R: begin
                AluSrcA    = SRCA_RS1;
                AluSrcB    = SRCB_RS2;
                AluOp      = dec_aluop;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                AluSrcA    = SRCA_RS1;
                AluSrcB    = SRCB_IMM;
                AluOp      = dec_aluop;
                state_next = (Op == OP_JALR) ? S_JALR : S_ALU_WB;
            end
            S_MEM_ADDR: begin
                AluSrcA    = SRCA_RS1;
                AluSrcB    = SRCB_IMM;
                Immsrc     = (Op == OP_SW) ? IMM_S : IMM_I;
                state_next = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady) begin
                    state_next = S_MEM_WB;
                end else if (tmo_hit) begin
                    state_next    = S_ERROR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                Immsrc   = IMM_S;
                if (MemReady) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (tmo_hit) begin
                    state_next    = S_ERROR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
            S_ALU_WB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                AluSrcA    = SRCA_RS1;
                AluSrcB    = SRCB_RS2;
                AluOp      = ALU_SUB;
                Immsrc     = IMM_B;
                PcEn       = br_taken;
                ResultSrc  = RES_ALUOUT;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL, S_JALR: begin
                PcEn       = 1'b1;
                ResultSrc  = RES_ALUOUT;
                AluSrcA    = SRCA_OLDPC;
                AluSrcB    = SRCB_FOUR;
                state_next = S_ALU_WB;
            end
            S_LUI: begin
                AluSrcA    = SRCA_ZERO;
                AluSrcB    = SRCB_IMM;
                Immsrc     = IMM_U;
                ResultSrc  = RES_IMM;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_AUIPC: begin
                AluSrcA    = SRCA_OLDPC;
                AluSrcB    = SRCB_IMM;
                Immsrc     = IMM_U;
                state_next = S_ALU_WB;
            end
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Stall counter, sticky error capture and retirement count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            inst_ret_q <= '0;
        end else begin
            if (MemReq && !MemReady && state_next == state) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end
            if (state != S_ERROR && state_next == S_ERROR) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_next;
            end
            if (retire) begin
                inst_ret_q <= inst_ret_q + CNT_W'(1);
            end
        end
    end

    assign Err     = err_q;
    assign ErrCode = err_code_q;
    assign InstRet = inst_ret_q;

endmodule

// File: tb/tb_mc_controller_hs.sv
// Directed bench: one restricted instance (timeout 4, no LUI/AUIPC) and one default instance.
module tb_mc_controller_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  Op;
    logic [2:0]  F3;
    logic [6:0]  F7;
    logic        Zero;
    logic        SignBit;
    logic        MemReady;

    logic        MemReq, MemWrite, AdrSrc, PcEn, IrWrite, RegWrite, Err;
    logic [2:0]  Immsrc, AluOp;
    logic [1:0]  AluSrcA, AluSrcB, ResultSrc, ErrCode;
    logic [31:0] InstRet;

    logic        u_MemReq, u_MemWrite, u_AdrSrc, u_PcEn, u_IrWrite, u_RegWrite, u_Err;
    logic [2:0]  u_Immsrc, u_AluOp;
    logic [1:0]  u_AluSrcA, u_AluSrcB, u_ResultSrc, u_ErrCode;
    logic [31:0] u_InstRet;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ret  = 32'd0;

    always #5 clk = ~clk;

    mc_controller_hs #(
        .MEM_TIMEOUT (4),
        .EN_UPPER    (1'b0),
        .EN_JALR     (1'b1),
        .CNT_W       (32)
    ) dut (
        .clk (clk), .rst (rst), .Op (Op), .F3 (F3), .F7 (F7),
        .Zero (Zero), .SignBit (SignBit), .MemReady (MemReady),
        .MemReq (MemReq), .MemWrite (MemWrite), .AdrSrc (AdrSrc), .PcEn (PcEn),
        .IrWrite (IrWrite), .RegWrite (RegWrite), .Immsrc (Immsrc),
        .AluSrcA (AluSrcA), .AluSrcB (AluSrcB), .AluOp (AluOp),
        .ResultSrc (ResultSrc), .Err (Err), .ErrCode (ErrCode), .InstRet (InstRet)
    );

    mc_controller_hs dut_full (
        .clk (clk), .rst (rst), .Op (Op), .F3 (F3), .F7 (F7),
        .Zero (Zero), .SignBit (SignBit), .MemReady (MemReady),
        .MemReq (u_MemReq), .MemWrite (u_MemWrite), .AdrSrc (u_AdrSrc), .PcEn (u_PcEn),
        .IrWrite (u_IrWrite), .RegWrite (u_RegWrite), .Immsrc (u_Immsrc),
        .AluSrcA (u_AluSrcA), .AluSrcB (u_AluSrcB), .AluOp (u_AluOp),
        .ResultSrc (u_ResultSrc), .Err (u_Err), .ErrCode (u_ErrCode), .InstRet (u_InstRet)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic rdy);
        Op       = op;
        F3       = f3;
        F7       = f7;
        MemReady = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        MemReady = 1'b0;
        tick();
        rst      = 1'b0;
        exp_ret  = 32'd0;
    endtask

    // Zero-wait FETCH then DECODE; leaves the bench in the first execute cycle.
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [2:0] exp_imm);
        set_in(op, f3, f7, 1'b1);
        check("fetch_irwrite", 32'(IrWrite), 1);
        check("fetch_pcen", 32'(PcEn), 1);
        tick();
        set_in(op, f3, f7, 1'b0);
        check("decode_memreq", 32'(MemReq), 0);
        check("decode_immsrc", 32'(Immsrc), 32'(exp_imm));
        tick();
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] exp_alu, input logic [1:0] exp_srcb);
        fetch_decode(op, f3, f7, 3'b000);
        check("exec_aluop", 32'(AluOp), 32'(exp_alu));
        check("exec_srcb", 32'(AluSrcB), 32'(exp_srcb));
        check("exec_regwrite", 32'(RegWrite), 0);
        tick();
        check("aluwb_regwrite", 32'(RegWrite), 1);
        check("aluwb_result", 32'(ResultSrc), 0);
        tick();
        exp_ret++;
        check("alu_instret", InstRet, exp_ret);
    endtask

    task automatic run_branch(input logic [2:0] f3, input logic z, input logic s,
                              input logic exp_pcen);
        fetch_decode(7'b1100011, f3, 7'd0, 3'b010);
        Zero    = z;
        SignBit = s;
        #1;
        check("branch_pcen", 32'(PcEn), 32'(exp_pcen));
        check("branch_aluop", 32'(AluOp), 1);
        tick();
        Zero    = 1'b0;
        SignBit = 1'b0;
        exp_ret++;
        check("branch_instret", InstRet, exp_ret);
        check("branch_next_fetch", 32'(MemReq), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Op = 7'd0; F3 = 3'd0; F7 = 7'd0; Zero = 1'b0; SignBit = 1'b0; MemReady = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        check("rst_memreq", 32'(MemReq), 1);
        check("rst_adrsrc", 32'(AdrSrc), 0);
        check("rst_irwrite", 32'(IrWrite), 0);
        check("rst_regwrite", 32'(RegWrite), 0);
        check("rst_srcb", 32'(AluSrcB), 2);
        check("rst_result", 32'(ResultSrc), 2);
        check("rst_err", 32'(Err), 0);
        check("rst_errcode", 32'(ErrCode), 0);
        check("rst_instret", InstRet, 0);
        rst = 1'b0;

        // R-type and I-ALU arithmetic
        run_alu(7'b0110011, 3'b000, 7'b0000000, 3'b000, 2'b00);
        run_alu(7'b0110011, 3'b000, 7'b0100000, 3'b001, 2'b00);
        run_alu(7'b0110011, 3'b111, 7'b0000000, 3'b010, 2'b00);
        run_alu(7'b0110011, 3'b011, 7'b0000000, 3'b110, 2'b00);
        run_alu(7'b0010011, 3'b100, 7'b0000000, 3'b101, 2'b01);
        run_alu(7'b0010011, 3'b010, 7'b0000000, 3'b100, 2'b01);
        run_alu(7'b0010011, 3'b110, 7'b0000000, 3'b011, 2'b01);

        // lw with three wait states
        fetch_decode(7'b0000011, 3'b010, 7'd0, 3'b000);
        check("lw_addr_srca", 32'(AluSrcA), 2);
        check("lw_addr_srcb", 32'(AluSrcB), 1);
        check("lw_addr_memreq", 32'(MemReq), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(7'b0000011, 3'b010, 7'd0, 1'b0);
            check("lw_wait_memreq", 32'(MemReq), 1);
            check("lw_wait_adrsrc", 32'(AdrSrc), 1);
            check("lw_wait_memwrite", 32'(MemWrite), 0);
            tick();
        end
        set_in(7'b0000011, 3'b010, 7'd0, 1'b1);
        check("lw_ready_memreq", 32'(MemReq), 1);
        tick();
        set_in(7'b0000011, 3'b010, 7'd0, 1'b0);
        check("lw_wb_result", 32'(ResultSrc), 1);
        check("lw_wb_regwrite", 32'(RegWrite), 1);
        check("lw_wb_err", 32'(Err), 0);
        tick();
        exp_ret++;
        check("lw_instret", InstRet, exp_ret);

        // sw, zero wait
        fetch_decode(7'b0100011, 3'b010, 7'd0, 3'b000);
        check("sw_addr_immsrc", 32'(Immsrc), 1);
        tick();
        set_in(7'b0100011, 3'b010, 7'd0, 1'b1);
        check("sw_memwrite", 32'(MemWrite), 1);
        check("sw_adrsrc", 32'(AdrSrc), 1);
        tick();
        exp_ret++;
        check("sw_instret", InstRet, exp_ret);

        run_branch(3'b000, 1'b1, 1'b0, 1'b1);
        run_branch(3'b001, 1'b1, 1'b0, 1'b0);
        run_branch(3'b100, 1'b0, 1'b1, 1'b1);
        run_branch(3'b101, 1'b0, 1'b1, 1'b0);
        run_branch(3'b000, 1'b0, 1'b0, 1'b0);

        // JAL
        fetch_decode(7'b1101111, 3'b000, 7'd0, 3'b011);
        check("jal_pcen", 32'(PcEn), 1);
        check("jal_srca", 32'(AluSrcA), 1);
        check("jal_srcb", 32'(AluSrcB), 2);
        tick();
        check("jal_wb_regwrite", 32'(RegWrite), 1);
        tick();
        exp_ret++;
        check("jal_instret", InstRet, exp_ret);

        // JALR
        fetch_decode(7'b1100111, 3'b000, 7'd0, 3'b000);
        check("jalr_exec_pcen", 32'(PcEn), 0);
        check("jalr_exec_srca", 32'(AluSrcA), 2);
        tick();
        check("jalr_pcen", 32'(PcEn), 1);
        check("jalr_srca", 32'(AluSrcA), 1);
        tick();
        check("jalr_wb_regwrite", 32'(RegWrite), 1);
        tick();
        exp_ret++;
        check("jalr_instret", InstRet, exp_ret);
        check("full_instret", u_InstRet, exp_ret);

        // MemReady on the timeout-boundary cycle completes the fetch
        for (int i = 0; i < 3; i++) begin
            set_in(7'b0010011, 3'b000, 7'd0, 1'b0);
            check("bound_wait_memreq", 32'(MemReq), 1);
            tick();
        end
        set_in(7'b0010011, 3'b000, 7'd0, 1'b1);
        check("bound_irwrite", 32'(IrWrite), 1);
        tick();
        set_in(7'b0010011, 3'b000, 7'd0, 1'b0);
        check("bound_no_err", 32'(Err), 0);
        tick();
        tick();
        tick();
        exp_ret++;
        check("bound_instret", InstRet, exp_ret);

        // fetch timeout
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(7'b0110011, 3'b000, 7'd0, 1'b0);
            check("tmo_wait_err", 32'(Err), 0);
            check("tmo_wait_memreq", 32'(MemReq), 1);
            tick();
        end
        set_in(7'b0110011, 3'b000, 7'd0, 1'b1);
        check("tmo_err", 32'(Err), 1);
        check("tmo_errcode", 32'(ErrCode), 2);
        check("tmo_memreq", 32'(MemReq), 0);
        check("tmo_irwrite", 32'(IrWrite), 0);
        check("tmo_pcen", 32'(PcEn), 0);
        check("tmo_full_err", 32'(u_Err), 0);
        check("tmo_full_memreq", 32'(u_MemReq), 1);
        tick();
        check("tmo_sticky_err", 32'(Err), 1);
        check("tmo_sticky_memreq", 32'(MemReq), 0);
        check("tmo_sticky_instret", InstRet, 0);

        // LUI: illegal when disabled, executes on the default instance
        do_reset();
        fetch_decode(7'b0110111, 3'b000, 7'd0, 3'b000);
        check("lui_off_err", 32'(Err), 1);
        check("lui_off_errcode", 32'(ErrCode), 1);
        check("lui_off_regwrite", 32'(RegWrite), 0);
        check("lui_regwrite", 32'(u_RegWrite), 1);
        check("lui_result", 32'(u_ResultSrc), 3);
        check("lui_immsrc", 32'(u_Immsrc), 4);
        tick();
        check("lui_instret", u_InstRet, 1);
        check("lui_next_fetch", 32'(u_MemReq), 1);
        check("lui_off_instret", InstRet, 0);

        // AUIPC on the default instance
        do_reset();
        fetch_decode(7'b0010111, 3'b000, 7'd0, 3'b000);
        check("auipc_srca", 32'(u_AluSrcA), 1);
        check("auipc_srcb", 32'(u_AluSrcB), 1);
        check("auipc_immsrc", 32'(u_Immsrc), 4);
        check("auipc_off_errcode", 32'(ErrCode), 1);
        tick();
        check("auipc_regwrite", 32'(u_RegWrite), 1);
        tick();
        check("auipc_instret", u_InstRet, 1);

        // unsupported funct7 on R-type
        do_reset();
        fetch_decode(7'b0110011, 3'b000, 7'b0000001, 3'b000);
        check("badf7_err", 32'(Err), 1);
        check("badf7_errcode", 32'(ErrCode), 1);
        check("badf7_regwrite", 32'(RegWrite), 0);

        // reset during a stalled store
        do_reset();
        check("store_rst_err_clear", 32'(Err), 0);
        fetch_decode(7'b0100011, 3'b010, 7'd0, 3'b000);
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(7'b0100011, 3'b010, 7'd0, 1'b0);
            check("store_wait_memwrite", 32'(MemWrite), 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("store_rst_memwrite", 32'(MemWrite), 0);
        check("store_rst_memreq", 32'(MemReq), 1);
        check("store_rst_adrsrc", 32'(AdrSrc), 0);
        check("store_rst_instret", InstRet, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
